// File: rtl/frame_buf_pkg.sv
// Shared types and default sizes for the UART frame buffer.
package frame_buf_pkg;

   localparam int unsigned FB_DATA_W = 8;
   localparam int unsigned FB_DEPTH  = 4096;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_PROC,
      ST_SEND_RD,
      ST_SEND_GO,
      ST_SEND_WAIT,
      ST_DONE
   } fb_state_t;

endpackage

// File: rtl/frame_ram.sv
// Single-port synchronous frame RAM, one-cycle read, write-first.
module frame_ram
   import frame_buf_pkg::*;
#(
   parameter int unsigned DATA_W = FB_DATA_W,
   parameter int unsigned DEPTH  = FB_DEPTH,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_d, rdata_q;

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   // Write-first: a write returns the new data on the read port.
   always_comb begin
      rdata_d = rdata_q;
      if (we) rdata_d = wdata;
      else    rdata_d = mem[addr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdata_q <= '0;
      else        rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/uart_frame_buffer.sv
// Frame store sequencing capture from the UART receiver, engine access and
// paced playback to the UART sender.
module uart_frame_buffer
   import frame_buf_pkg::*;
#(
   parameter int unsigned DATA_W = FB_DATA_W,
   parameter int unsigned DEPTH  = FB_DEPTH,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_start,
   input  logic              send_start,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_valid,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_start,
   input  logic              tx_busy,
   output logic              proc_en,
   input  logic [ADDR_W-1:0] proc_addr,
   input  logic              proc_we,
   input  logic [DATA_W-1:0] proc_wdata,
   output logic [DATA_W-1:0] proc_rdata,
   input  logic              proc_done,
   output logic              frame_full,
   output logic              frame_sent,
   output logic              overrun_err,
   output logic [ADDR_W:0]   count
);

   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

   fb_state_t         state_d, state_q;
   logic [CNT_W-1:0]  count_d, count_q;
   logic [DATA_W-1:0] tx_data_d, tx_data_q;
   logic              tx_start_d, tx_start_q;
   logic              proc_en_d, proc_en_q;
   logic              frame_full_d, frame_full_q;
   logic              frame_sent_d, frame_sent_q;
   logic              overrun_d, overrun_q;
   logic              send_armed_d, send_armed_q;
   logic              done_seen_d, done_seen_q;
   logic              wait_first_d, wait_first_q;
   logic              load_prev_q, send_prev_q;
   logic              load_edge, send_edge;

   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata, ram_rdata;

   assign load_edge = load_start & ~load_prev_q;
   assign send_edge = send_start & ~send_prev_q;

   frame_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
      .clk   (clk),
      .rst_n (reset),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      tx_data_d    = tx_data_q;
      tx_start_d   = 1'b0;
      frame_full_d = frame_full_q;
      frame_sent_d = frame_sent_q;
      overrun_d    = overrun_q;
      send_armed_d = send_armed_q;
      done_seen_d  = done_seen_q;
      wait_first_d = wait_first_q;
      ram_we       = 1'b0;
      ram_addr     = count_q[ADDR_W-1:0];
      ram_wdata    = rx_data;

      // Bytes arriving with a full frame outside capture are dropped and flagged.
      if (rx_valid && (state_q != ST_LOAD) && frame_full_q) overrun_d = 1'b1;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (load_edge) begin
               state_d      = ST_LOAD;
               count_d      = '0;
               overrun_d    = 1'b0;
               frame_full_d = 1'b0;
               frame_sent_d = 1'b0;
            end
         end
         ST_LOAD: begin
            if (rx_valid) begin
               ram_we  = 1'b1;
               count_d = count_q + CNT_W'(1);
               if (count_q == LAST_IDX) begin
                  state_d      = ST_PROC;
                  frame_full_d = 1'b1;
               end
            end
         end
         ST_PROC: begin
            ram_we    = proc_we;
            ram_addr  = proc_addr;
            ram_wdata = proc_wdata;
            if (send_edge) send_armed_d = 1'b1;
            if (proc_done) done_seen_d  = 1'b1;
            // Playback needs both engine completion and a send request, in any order.
            if ((proc_done || done_seen_q) && (send_edge || send_armed_q)) begin
               state_d      = ST_SEND_RD;
               count_d      = '0;
               send_armed_d = 1'b0;
               done_seen_d  = 1'b0;
            end
         end
         ST_SEND_RD: state_d = ST_SEND_GO;
         ST_SEND_GO: begin
            if (!tx_busy) begin
               tx_data_d    = ram_rdata;
               tx_start_d   = 1'b1;
               wait_first_d = 1'b1;
               state_d      = ST_SEND_WAIT;
            end
         end
         ST_SEND_WAIT: begin
            // Sender raises busy only after seeing tx_start, so skip the first cycle.
            if (wait_first_q) begin
               wait_first_d = 1'b0;
            end else if (!tx_busy) begin
               count_d = count_q + CNT_W'(1);
               if (count_q == LAST_IDX) begin
                  state_d      = ST_DONE;
                  frame_sent_d = 1'b1;
               end else begin
                  state_d = ST_SEND_RD;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      proc_en_d = (state_d == ST_PROC);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         count_q      <= '0;
         tx_data_q    <= '0;
         tx_start_q   <= 1'b0;
         proc_en_q    <= 1'b0;
         frame_full_q <= 1'b0;
         frame_sent_q <= 1'b0;
         overrun_q    <= 1'b0;
         send_armed_q <= 1'b0;
         done_seen_q  <= 1'b0;
         wait_first_q <= 1'b0;
         load_prev_q  <= 1'b0;
         send_prev_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         tx_data_q    <= tx_data_d;
         tx_start_q   <= tx_start_d;
         proc_en_q    <= proc_en_d;
         frame_full_q <= frame_full_d;
         frame_sent_q <= frame_sent_d;
         overrun_q    <= overrun_d;
         send_armed_q <= send_armed_d;
         done_seen_q  <= done_seen_d;
         wait_first_q <= wait_first_d;
         load_prev_q  <= load_start;
         send_prev_q  <= send_start;
      end
   end

   assign tx_data     = tx_data_q;
   assign tx_start    = tx_start_q;
   assign proc_en     = proc_en_q;
   assign proc_rdata  = ram_rdata;
   assign frame_full  = frame_full_q;
   assign frame_sent  = frame_sent_q;
   assign overrun_err = overrun_q;
   assign count       = count_q;

endmodule

// File: tb/tb_uart_frame_buffer.sv
// Directed bench for uart_frame_buffer with a 16-pixel frame and a busy sender model.
module tb_uart_frame_buffer;

   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned AW    = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          load_start = 1'b0;
   logic          send_start = 1'b0;
   logic [DW-1:0] rx_data = '0;
   logic          rx_valid = 1'b0;
   logic [DW-1:0] tx_data;
   logic          tx_start;
   logic          tx_busy = 1'b0;
   logic          proc_en;
   logic [AW-1:0] proc_addr = '0;
   logic          proc_we = 1'b0;
   logic [DW-1:0] proc_wdata = '0;
   logic [DW-1:0] proc_rdata;
   logic          proc_done = 1'b0;
   logic          frame_full;
   logic          frame_sent;
   logic          overrun_err;
   logic [AW:0]   count;

   int n_run  = 0;
   int n_fail = 0;
   int n_tx   = 0;
   int n_viol = 0;
   int busy_cnt = 0;
   logic [DW-1:0] tx_q [$];

   always #5 clk = ~clk;

   uart_frame_buffer #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .load_start  (load_start),
      .send_start  (send_start),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .tx_data     (tx_data),
      .tx_start    (tx_start),
      .tx_busy     (tx_busy),
      .proc_en     (proc_en),
      .proc_addr   (proc_addr),
      .proc_we     (proc_we),
      .proc_wdata  (proc_wdata),
      .proc_rdata  (proc_rdata),
      .proc_done   (proc_done),
      .frame_full  (frame_full),
      .frame_sent  (frame_sent),
      .overrun_err (overrun_err),
      .count       (count)
   );

   // Sender model: busy for 10 cycles after each accepted request.
   always @(posedge clk) begin
      if (tx_start) begin
         if (tx_busy) n_viol <= n_viol + 1;
         tx_q.push_back(tx_data);
         n_tx     <= n_tx + 1;
         busy_cnt <= 10;
         tx_busy  <= 1'b1;
      end else if (busy_cnt > 1) begin
         busy_cnt <= busy_cnt - 1;
      end else begin
         busy_cnt <= 0;
         tx_busy  <= 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run = n_run + 1;
      if (got !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic pulse_load();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
   endtask

   initial begin
      int n0;
      int n1;
      int t;

      // Reset state
      #12;
      check("rst_tx_start",   32'(tx_start),    32'd0);
      check("rst_tx_data",    32'(tx_data),     32'd0);
      check("rst_count",      32'(count),       32'd0);
      check("rst_frame_full", 32'(frame_full),  32'd0);
      check("rst_proc_en",    32'(proc_en),     32'd0);
      tick();
      reset = 1'b1;
      tick();

      // Capture 0x00..0x0F, with a stray send edge that must be ignored
      pulse_load();
      check("load_count0", 32'(count), 32'd0);
      for (int i = 0; i < 16; i++) begin
         rx_data  = 8'(i);
         rx_valid = 1'b1;
         if (i == 5) send_start = 1'b1;
         if (i == 6) send_start = 1'b0;
         tick();
         rx_valid = 1'b0;
         if (i == 7) begin
            check("load_mid_count",   32'(count),   32'd8);
            check("load_mid_proc_en", 32'(proc_en), 32'd0);
         end
         if (i == 14) check("load_not_full", 32'(frame_full), 32'd0);
      end
      check("load_full",    32'(frame_full), 32'd1);
      check("load_proc_en", 32'(proc_en),    32'd1);
      check("load_count16", 32'(count),      32'd16);

      // Engine read-back of stored frame
      for (int a = 0; a < 16; a++) begin
         proc_addr = AW'(a);
         tick();
         check("ram_rd", 32'(proc_rdata), 32'(a));
      end

      // Engine write then read
      proc_addr  = 4'd3;
      proc_wdata = 8'hFF;
      proc_we    = 1'b1;
      tick();
      proc_we = 1'b0;
      tick();
      check("proc_wr_rd", 32'(proc_rdata), 32'hFF);

      // Stray receive byte in PROC
      rx_data  = 8'hAA;
      rx_valid = 1'b1;
      tick();
      rx_valid  = 1'b0;
      check("overrun_set", 32'(overrun_err), 32'd1);
      proc_addr = 4'd0;
      tick();
      check("overrun_ram0", 32'(proc_rdata), 32'h00);

      // Send edge before done is remembered
      send_start = 1'b1;
      tick();
      send_start = 1'b0;
      tick();
      check("proc_hold", 32'(proc_en), 32'd1);
      n0 = n_tx;
      proc_done = 1'b1;
      tick();
      proc_done = 1'b0;
      check("proc_exit", 32'(proc_en), 32'd0);

      t = 0;
      while (!frame_sent && t < 2000) begin
         tick();
         t++;
      end
      check("send_timeout", 32'(t < 2000), 32'd1);
      check("send_n_tx",    32'(n_tx - n0), 32'd16);
      check("send_no_busy", 32'(n_viol),    32'd0);
      check("send_count",   32'(count),     32'd16);
      check("send_overrun_sticky", 32'(overrun_err), 32'd1);
      for (int i = 0; i < 16; i++) begin
         if (n0 + i < tx_q.size())
            check("send_byte", 32'(tx_q[n0 + i]), (i == 3) ? 32'hFF : 32'(i));
      end

      // New capture from DONE clears flags
      pulse_load();
      check("reload_overrun",  32'(overrun_err), 32'd0);
      check("reload_sent",     32'(frame_sent),  32'd0);
      check("reload_full",     32'(frame_full),  32'd0);
      check("reload_count",    32'(count),       32'd0);
      for (int i = 0; i < 16; i++) begin
         rx_data  = 8'(8'h20 + i);
         rx_valid = 1'b1;
         tick();
         rx_valid = 1'b0;
      end
      check("reload_full2", 32'(frame_full), 32'd1);
      n0 = n_tx;
      send_start = 1'b1;
      proc_done  = 1'b1;
      tick();
      send_start = 1'b0;
      proc_done  = 1'b0;

      // Abort with reset while the fifth byte is in flight
      t = 0;
      while ((n_tx - n0) < 5 && t < 1000) begin
         tick();
         t++;
      end
      check("abort_timeout", 32'(t < 1000), 32'd1);
      for (int i = 0; i < 5; i++) begin
         if (n0 + i < tx_q.size())
            check("abort_byte", 32'(tx_q[n0 + i]), 32'(8'h20 + i));
      end
      repeat (3) tick();
      #2 reset = 1'b0;
      #1;
      check("abort_tx_start", 32'(tx_start),   32'd0);
      check("abort_tx_data",  32'(tx_data),    32'd0);
      check("abort_count",    32'(count),      32'd0);
      check("abort_full",     32'(frame_full), 32'd0);
      check("abort_proc_en",  32'(proc_en),    32'd0);
      check("abort_rdata",    32'(proc_rdata), 32'd0);
      tick();
      tick();
      reset = 1'b1;
      n1 = n_tx;
      repeat (50) tick();
      check("abort_no_tx",    32'(n_tx - n1), 32'd0);
      check("abort_idle_cnt", 32'(count),     32'd0);
      check("abort_no_sent",  32'(frame_sent), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
